// File: rtl/uart_tx_sb_ctrl_if.sv
// System-bus slave port of the UART transmitter: request, address, store data and load data.
// Latency: read_data_o is registered and valid the cycle after a sampled load.
// Backpressure: none; every request completes in one cycle, and a store to a full FIFO is dropped.
interface uart_tx_sb_ctrl_if;
  logic [31:0] addr_i;
  logic        req_i;
  logic [31:0] write_data_i;
  logic        write_enable_i;
  logic [31:0] read_data_o;

  modport master (
    output addr_i,
    output req_i,
    output write_data_i,
    output write_enable_i,
    input  read_data_o
  );

  modport slave (
    input  addr_i,
    input  req_i,
    input  write_data_i,
    input  write_enable_i,
    output read_data_o
  );
endinterface

// File: rtl/uart_tx_sb_ctrl.sv
// UART transmitter on the system bus: byte FIFO feeding an 8-bit serialiser with optional even parity and 1 or 2 stop bits.
// Latency: a DATA store into an idle, empty unit drives the start bit from the next edge; loads return one cycle later.
// Backpressure: none on the bus; a DATA store while the FIFO is full is dropped and sets the sticky overflow flag.
module uart_tx_sb_ctrl #(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd174
) (
  input  logic               clk_i,
  input  logic               resetn_i,
  uart_tx_sb_ctrl_if.slave   bus,
  output logic               tx_o
);

  localparam int          AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  localparam logic [23:0] OFF_DATA   = 24'h00;
  localparam logic [23:0] OFF_STATUS = 24'h08;
  localparam logic [23:0] OFF_DIV    = 24'h0C;
  localparam logic [23:0] OFF_PARITY = 24'h10;
  localparam logic [23:0] OFF_STOP2  = 24'h14;
  localparam logic [23:0] OFF_SRST   = 24'h24;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Configuration registers
  logic [15:0]   r_div;
  logic          r_par_en;
  logic          r_stop2;

  // FIFO storage and bookkeeping
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          r_ovf;

  // Serialiser state; div/parity/stop settings are frozen per frame
  state_t        r_state;
  logic [7:0]    r_shift;
  logic          r_parity;
  logic [2:0]    r_bit_idx;
  logic [15:0]   r_baud;
  logic [15:0]   r_div_l;
  logic          r_par_l;
  logic          r_stop2_l;
  logic          r_stop_2nd;
  logic          r_tx;
  logic [31:0]   r_rdata;

  logic [23:0]   w_off;
  logic          w_wr;
  logic          w_rd;
  logic          w_data_wr;
  logic          w_srst;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_ovf_set;
  logic          w_baud_done;
  logic          w_stop_last;
  logic          w_pop;
  logic          w_busy;
  logic [7:0]    w_head;
  logic [15:0]   w_div_wr_val;
  logic          w_unused_bits;

  assign w_off         = bus.addr_i[23:0];
  assign w_wr          = bus.req_i & bus.write_enable_i;
  assign w_rd          = bus.req_i & ~bus.write_enable_i;
  assign w_data_wr     = w_wr && (w_off == OFF_DATA);
  assign w_srst        = w_wr && (w_off == OFF_SRST) && bus.write_data_i[0];
  assign w_full        = (r_count == DEPTH_C);
  assign w_empty       = (r_count == '0);
  // Full is judged on the registered count, so a pop in the same cycle does not make room
  assign w_push        = w_data_wr & ~w_full;
  assign w_ovf_set     = w_data_wr & w_full;
  assign w_baud_done   = (r_baud == 16'd0);
  assign w_stop_last   = ~r_stop2_l | r_stop_2nd;
  // Pop in IDLE, or at the very end of the last stop bit so frames run back to back
  assign w_pop         = ~w_empty &&
                         ((r_state == S_IDLE) ||
                          ((r_state == S_STOP) && w_baud_done && w_stop_last));
  assign w_busy        = (r_state != S_IDLE) | ~w_empty;
  assign w_head        = r_mem[r_rptr];
  // A divisor below 2 would make a bit shorter than the counter can express cleanly
  assign w_div_wr_val  = (bus.write_data_i[15:0] < 16'd2) ? 16'd2 : bus.write_data_i[15:0];
  assign w_unused_bits = ^{bus.addr_i[31:24], bus.write_data_i[31:16]};

  assign tx_o            = r_tx;
  assign bus.read_data_o = r_rdata;

  // FIFO data array: written on accepted pushes, no reset needed
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= bus.write_data_i[7:0];
    end
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (w_srst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Configuration register writes
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_div    <= DEFAULT_DIV;
      r_par_en <= 1'b0;
      r_stop2  <= 1'b0;
    end else if (w_srst) begin
      r_div    <= DEFAULT_DIV;
      r_par_en <= 1'b0;
      r_stop2  <= 1'b0;
    end else if (w_wr) begin
      case (w_off)
        OFF_DIV:    r_div    <= w_div_wr_val;
        OFF_PARITY: r_par_en <= bus.write_data_i[0];
        OFF_STOP2:  r_stop2  <= bus.write_data_i[0];
        default:    ;
      endcase
    end
  end

  // Registered load data; holds its value when no load is sampled
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_rdata <= 32'd0;
    end else if (w_srst) begin
      r_rdata <= 32'd0;
    end else if (w_rd) begin
      case (w_off)
        OFF_STATUS: r_rdata <= {28'd0, r_ovf, w_empty, w_full, w_busy};
        OFF_DIV:    r_rdata <= {16'd0, r_div};
        OFF_PARITY: r_rdata <= {31'd0, r_par_en};
        OFF_STOP2:  r_rdata <= {31'd0, r_stop2};
        default:    r_rdata <= 32'd0;
      endcase
    end
  end

  // Transmit FSM: each bit lasts r_div_l cycles, counting the baud counter down to zero
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_state    <= S_IDLE;
      r_tx       <= 1'b1;
      r_shift    <= 8'd0;
      r_parity   <= 1'b0;
      r_bit_idx  <= 3'd0;
      r_baud     <= 16'd0;
      r_div_l    <= DEFAULT_DIV;
      r_par_l    <= 1'b0;
      r_stop2_l  <= 1'b0;
      r_stop_2nd <= 1'b0;
    end else if (w_srst) begin
      r_state    <= S_IDLE;
      r_tx       <= 1'b1;
      r_shift    <= 8'd0;
      r_parity   <= 1'b0;
      r_bit_idx  <= 3'd0;
      r_baud     <= 16'd0;
      r_div_l    <= DEFAULT_DIV;
      r_par_l    <= 1'b0;
      r_stop2_l  <= 1'b0;
      r_stop_2nd <= 1'b0;
    end else if (w_pop) begin
      r_shift    <= w_head;
      r_parity   <= ^w_head;
      r_div_l    <= r_div;
      r_par_l    <= r_par_en;
      r_stop2_l  <= r_stop2;
      r_baud     <= r_div - 16'd1;
      r_bit_idx  <= 3'd0;
      r_stop_2nd <= 1'b0;
      r_tx       <= 1'b0;
      r_state    <= S_START;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
        end
        S_START: begin
          if (w_baud_done) begin
            r_baud    <= r_div_l - 16'd1;
            r_bit_idx <= 3'd0;
            r_tx      <= r_shift[0];
            r_state   <= S_DATA;
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end
        S_DATA: begin
          if (w_baud_done) begin
            r_baud <= r_div_l - 16'd1;
            if (r_bit_idx == 3'd7) begin
              if (r_par_l) begin
                r_tx    <= r_parity;
                r_state <= S_PARITY;
              end else begin
                r_tx       <= 1'b1;
                r_stop_2nd <= 1'b0;
                r_state    <= S_STOP;
              end
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_tx      <= r_shift[1];
              r_shift   <= {1'b0, r_shift[7:1]};
            end
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end
        S_PARITY: begin
          if (w_baud_done) begin
            r_baud     <= r_div_l - 16'd1;
            r_tx       <= 1'b1;
            r_stop_2nd <= 1'b0;
            r_state    <= S_STOP;
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end
        S_STOP: begin
          if (w_baud_done) begin
            if (!w_stop_last) begin
              r_stop_2nd <= 1'b1;
              r_baud     <= r_div_l - 16'd1;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sb_ctrl.sv
// Directed bench for uart_tx_sb_ctrl: register access, frame shapes, FIFO fill/overflow, soft and hard reset.
// Latency: bus tasks return 1 time unit after the sampling edge, so outputs are read away from the edge.
// Backpressure: none to model; FIFO overflow is provoked with a back-to-back store burst.
module tb_uart_tx_sb_ctrl;

  localparam logic [31:0] A_DATA   = 32'h00;
  localparam logic [31:0] A_STATUS = 32'h08;
  localparam logic [31:0] A_DIV    = 32'h0C;
  localparam logic [31:0] A_PARITY = 32'h10;
  localparam logic [31:0] A_STOP2  = 32'h14;
  localparam logic [31:0] A_SRST   = 32'h24;

  logic clk_i;
  logic resetn_i;
  logic tx_o;
  int   n_chk;
  int   n_err;

  uart_tx_sb_ctrl_if bus ();

  uart_tx_sb_ctrl #(
    .FIFO_DEPTH  (8),
    .DEFAULT_DIV (16'd174)
  ) dut (
    .clk_i    (clk_i),
    .resetn_i (resetn_i),
    .bus      (bus),
    .tx_o     (tx_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    bus.req_i          = 1'b1;
    bus.write_enable_i = 1'b1;
    bus.addr_i         = addr;
    bus.write_data_i   = data;
    @(posedge clk_i);
    #1;
    bus.req_i          = 1'b0;
    bus.write_enable_i = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    bus.req_i          = 1'b1;
    bus.write_enable_i = 1'b0;
    bus.addr_i         = addr;
    @(posedge clk_i);
    #1;
    bus.req_i = 1'b0;
    data      = bus.read_data_o;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Expected line level c cycles into a frame: start, 8 data LSB first, optional even parity, stop(s)
  function automatic logic frame_bit(input logic [7:0] b, input int div, input int par, input int c);
    int idx;
    idx = c / div;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (idx == 9 && par != 0) return ^b;
    return 1'b1;
  endfunction

  // Called right after the DATA store's sampling edge; follows the whole frame, then idle and STATUS
  task automatic frame_check(input string tag, input logic [7:0] b, input int div, input int par, input int stop2);
    logic [31:0] rd;
    int          len;
    len = div * (10 + par + stop2);
    chk({tag, "_pre"}, {31'd0, tx_o}, 32'd1);
    for (int c = 0; c < len; c++) begin
      @(posedge clk_i);
      #1;
      chk(tag, {31'd0, tx_o}, {31'd0, frame_bit(b, div, par, c)});
    end
    @(posedge clk_i);
    #1;
    chk({tag, "_idle"}, {31'd0, tx_o}, 32'd1);
    bus_read(A_STATUS, rd);
    chk({tag, "_status"}, rd, 32'h4);
  endtask

  initial begin
    logic [31:0] rd;
    n_chk              = 0;
    n_err              = 0;
    resetn_i           = 1'b0;
    bus.req_i          = 1'b0;
    bus.write_enable_i = 1'b0;
    bus.addr_i         = 32'd0;
    bus.write_data_i   = 32'd0;

    // Power-on reset
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_tx", {31'd0, tx_o}, 32'd1);
    chk("rst_rdata", bus.read_data_o, 32'd0);
    resetn_i = 1'b1;
    wait_cycles(2);
    bus_read(A_STATUS, rd);
    chk("rst_status", rd, 32'h4);
    bus_read(A_DIV, rd);
    chk("rst_div", rd, 32'd174);
    bus_read(A_PARITY, rd);
    chk("rst_parity", rd, 32'd0);

    // 0xA5, DIV=4, no parity, one stop bit
    bus_write(A_DIV, 32'd4);
    bus_read(A_DIV, rd);
    chk("div4", rd, 32'd4);
    bus_write(A_DATA, 32'hA5);
    frame_check("frm_a5", 8'hA5, 4, 0, 0);

    // 0x07, DIV=4, even parity, two stop bits
    bus_write(A_PARITY, 32'd1);
    bus_write(A_STOP2, 32'd1);
    bus_read(A_STOP2, rd);
    chk("stop2_rb", rd, 32'd1);
    bus_write(A_DATA, 32'h07);
    frame_check("frm_07", 8'h07, 4, 1, 1);
    bus_write(A_PARITY, 32'd0);
    bus_write(A_STOP2, 32'd0);

    // Burst of 10 stores at DIV=2: 0x00 pops at once, 0x01..0x08 fill, 0x09 overflows
    bus_write(A_DIV, 32'd2);
    for (int cyc = 0; cyc <= 181; cyc++) begin
      if (cyc < 10) begin
        bus.req_i          = 1'b1;
        bus.write_enable_i = 1'b1;
        bus.addr_i         = A_DATA;
        bus.write_data_i   = 32'(cyc);
      end else if (cyc == 10) begin
        bus.req_i          = 1'b1;
        bus.write_enable_i = 1'b0;
        bus.addr_i         = A_STATUS;
      end else begin
        bus.req_i          = 1'b0;
        bus.write_enable_i = 1'b0;
      end
      @(posedge clk_i);
      #1;
      if (cyc >= 1 && cyc <= 180) begin
        chk("burst_tx", {31'd0, tx_o},
            {31'd0, frame_bit(8'((cyc - 1) / 20), 2, 0, (cyc - 1) % 20)});
      end
      if (cyc == 10) chk("burst_status_full", bus.read_data_o, 32'hB);
      if (cyc == 181) chk("burst_tx_idle", {31'd0, tx_o}, 32'd1);
    end
    bus.req_i = 1'b0;
    wait_cycles(2);
    bus_read(A_STATUS, rd);
    chk("burst_status_ovf", rd, 32'hC);

    // Soft reset in the middle of a long start bit
    bus_write(A_DIV, 32'd8);
    bus_write(A_PARITY, 32'd1);
    bus_write(A_STOP2, 32'd1);
    bus_write(A_DATA, 32'h00);
    bus_write(A_DATA, 32'h00);
    wait_cycles(4);
    chk("srst_pre_tx", {31'd0, tx_o}, 32'd0);
    bus_write(A_SRST, 32'd1);
    chk("srst_tx", {31'd0, tx_o}, 32'd1);
    bus_read(A_STATUS, rd);
    chk("srst_status", rd, 32'h4);
    bus_read(A_DIV, rd);
    chk("srst_div", rd, 32'd174);
    bus_read(A_PARITY, rd);
    chk("srst_parity", rd, 32'd0);
    bus_read(A_STOP2, rd);
    chk("srst_stop2", rd, 32'd0);
    wait_cycles(20);
    chk("srst_tx_quiet", {31'd0, tx_o}, 32'd1);

    // Hard reset in the middle of a frame at the default divisor
    bus_write(A_DATA, 32'h00);
    wait_cycles(10);
    chk("hrst_pre_tx", {31'd0, tx_o}, 32'd0);
    #2;
    resetn_i = 1'b0;
    #1;
    chk("hrst_tx_async", {31'd0, tx_o}, 32'd1);
    repeat (2) @(posedge clk_i);
    #1;
    resetn_i = 1'b1;
    wait_cycles(1);
    bus_read(A_STATUS, rd);
    chk("hrst_status", rd, 32'h4);
    bus_read(A_DIV, rd);
    chk("hrst_div", rd, 32'd174);

    // Divisor clamping, then a frame at the clamped divisor
    bus_write(A_DIV, 32'd0);
    bus_read(A_DIV, rd);
    chk("div0_clamp", rd, 32'd2);
    bus_write(A_DIV, 32'd1);
    bus_read(A_DIV, rd);
    chk("div1_clamp", rd, 32'd2);
    bus_write(A_DATA, 32'h5A);
    frame_check("frm_5a", 8'h5A, 2, 0, 0);

    // Unmapped offset and upper address bits
    bus_read(32'h30, rd);
    chk("unmapped_rd", rd, 32'd0);
    bus_write(32'h30, 32'hFFFF_FFFF);
    bus_read(A_DIV, rd);
    chk("unmapped_div", rd, 32'd2);
    bus_read(A_PARITY, rd);
    chk("unmapped_parity", rd, 32'd0);
    bus_read(A_DATA, rd);
    chk("data_rd_zero", rd, 32'd0);
    bus_read(32'h5500_000C, rd);
    chk("upper_addr_ignored", rd, 32'd2);
    bus_read(A_STATUS, rd);
    chk("final_status", rd, 32'h4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
